pcm_voice_mix_scheduler: RTL and testbench
==========================================

Name: pcm_voice_mix_scheduler

Overview:
- Per-frame sample scheduler and mixer in front of the 16-bit stereo PCM serializer.
- Runs on the DAC bit clock and tracks the 32-bit serializer frame.
- Once per frame, polls up to NUM_VOICES tracker voices over one shared sample bus and sums their stereo samples.
- Presents the mixed left/right word with a valid flag, stable across the serializer's frame-load edge.

Parameters:
- NUM_VOICES, 4, number of voice sources polled per frame (1..8).
- ACK_TIMEOUT, 4, cycles a voice may take to ack before it is skipped (1..7).
- FRAME_BITS, 32, bit clocks per stereo frame; must match the serializer.

Ports:
- bit_clock_in  in  1  DAC bit clock; also the serializer's clock.
- rst_active_high  in  1  asynchronous, active-high reset; shared with the serializer so frame counts align.
- mix_enable  in  1  0 = no polling, output forced silent.
- voice_mute  in  NUM_VOICES  1 = voice skipped this frame (sampled at frame start).
- voice_req  out  NUM_VOICES  one-hot request to the selected voice.
- voice_sel  out  3  index of the currently requested voice.
- voice_ack  in  1  shared ack from the selected voice.
- voice_left  in  16  shared signed left sample; valid when voice_ack=1.
- voice_right  in  16  shared signed right sample; valid when voice_ack=1.
- pcm_data_left  out  16  mixed signed left sample, to the serializer.
- pcm_data_right  out  16  mixed signed right sample, to the serializer.
- pcm_data_valid  out  1  mixed word valid, to the serializer.
- frame_strobe  out  1  one-cycle pulse when frame_count==0.
- overrun  out  1  sticky flag: poll sequence did not finish by the commit point.
- overrun_clr  in  1  synchronous clear of overrun.

Behaviour:
- Clock and reset: one clock, bit_clock_in. Reset is asynchronous and active-high on rst_active_high.
- Reset values: all outputs 0, frame_count=0, state=IDLE, accumulators 0.
- Frame counter: frame_count runs 0..FRAME_BITS-1 and wraps. Serializer frame load occurs on the edge where its count is 31; this block's count is equal.
- Commit: on the edge where frame_count goes 30->31, pcm_data_left, pcm_data_right and pcm_data_valid update. They then hold for a full frame, so they are stable at the load edge. Effective latency is voice ack to DAC in the next frame.
- FSM states are IDLE, SELECT, WAIT, DONE.
  - IDLE: at frame_count==0 with mix_enable=1, clear accumulators, latch voice_mute, set idx=0, go to SELECT.
  - SELECT: if voice idx is muted, advance idx. Otherwise assert voice_req[idx], drive voice_sel=idx, clear the timeout counter and go to WAIT. At most one voice is handled per cycle. When idx==NUM_VOICES, go to DONE.
  - WAIT: voice_req is held high. If voice_ack=1, add the sign-extended voice_left/voice_right into 19-bit accumulators, set any_ack, drop voice_req next cycle, idx++, go to SELECT. If the timeout counter reaches ACK_TIMEOUT without an ack, skip the voice (no add), idx++, go to SELECT.
  - DONE: wait for the commit edge, then go to IDLE.
- voice_req: at most one bit high at any time. voice_req is deasserted in every state except WAIT.
- Output rules at commit:
  - pcm_data_valid = any_ack.
  - If no voice acked, data = 0.
  - Accumulators are reduced to 16 bits per the optional feature.
- Overrun: if the state is not DONE or IDLE at the commit edge, commit the partial sums, set overrun=1 and abort to IDLE with voice_req cleared.
  - If overrun_clr and a new overrun occur in the same cycle, set wins.
- mix_enable=0: at frame_count==0, stay in IDLE. At the next commit, outputs are 0 and valid=0. Deassertion mid-sequence completes the current frame.
- Ack when voice_req is low is ignored.
- Reset mid-sequence: immediate return to reset values, including voice_req=0.

Optional Feature:
- Macro: PCM_MIX_SATURATE_EN.
- Defined: each 19-bit accumulator is clamped to [-32768, 32767] at commit.
- Undefined: the low 16 bits are taken (two's-complement wrap).

Test Plan:
- Basic mix: 4 voices ack after 1 cycle with L/R = 0x0100, 0x0200, 0x0300, 0x0400 -> at count 31, pcm_data_left=pcm_data_right=0x0A00, valid=1, overrun=0.
- Mute and timeout:
  - voice_mute=4'b0010; voice 2 never acks; voices 0 and 3 give L=0x1000.
  - Required: voice_req[1] never asserts; voice_req[2] high for exactly ACK_TIMEOUT=4 cycles; left=0x2000.
- Saturation: 4 voices each L=0x7000, R=0x9000.
  - With PCM_MIX_SATURATE_EN: left=0x7FFF, right=0x8000.
  - Without it: left=0xC000, right=0x4000.
- Overrun:
  - Stimulus: NUM_VOICES=8, ACK_TIMEOUT=7, no acks.
  - At commit: overrun=1, valid=0, voice_req=0.
  - overrun_clr pulse: overrun=0 next cycle.
- Enable/reset:
  - mix_enable=0: no voice_req activity in the frame, and valid=0 at the next commit.
  - Reset asserted during WAIT: all outputs 0 asynchronously.
  - After reset release: frame_strobe at the first edge where frame_count==0, aligned with the serializer's bit_counter 0.

Source files
------------

// File: rtl/pcm_voice_mix_scheduler.sv
// Per-frame voice poller and stereo mixer feeding the 16-bit PCM serializer.
// Define PCM_MIX_SATURATE_EN to clamp the mix instead of wrapping it.
module pcm_voice_mix_scheduler #(
  parameter int NUM_VOICES  = 4,
  parameter int ACK_TIMEOUT = 4,
  parameter int FRAME_BITS  = 32
) (
  input  logic                  bit_clock_in,
  input  logic                  rst_active_high,
  input  logic                  mix_enable,
  input  logic [NUM_VOICES-1:0] voice_mute,
  output logic [NUM_VOICES-1:0] voice_req,
  output logic [2:0]            voice_sel,
  input  logic                  voice_ack,
  input  logic [15:0]           voice_left,
  input  logic [15:0]           voice_right,
  output logic [15:0]           pcm_data_left,
  output logic [15:0]           pcm_data_right,
  output logic                  pcm_data_valid,
  output logic                  frame_strobe,
  output logic                  overrun,
  input  logic                  overrun_clr
);

  localparam int CW = $clog2(FRAME_BITS);
  localparam logic [CW-1:0] LAST   = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] COMMIT = CW'(FRAME_BITS - 2);
  localparam logic [3:0]    IDX_END = 4'(NUM_VOICES);
  localparam logic [2:0]    TO_LAST = 3'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    WAIT,
    DONE
  } state_t;

  state_t                  state;
  logic [CW-1:0]           frame_count;
  logic [3:0]              idx;
  logic [2:0]              tcnt;
  logic [NUM_VOICES-1:0]   mute_q;
  logic signed [18:0]      acc_l;
  logic signed [18:0]      acc_r;
  logic                    any_ack;
  logic [NUM_VOICES-1:0]   sel_onehot;

  assign sel_onehot = NUM_VOICES'(1) << idx;

  function automatic logic [15:0] reduce(input logic signed [18:0] a);
`ifdef PCM_MIX_SATURATE_EN
    if (a > 19'sd32767)
      reduce = 16'h7fff;
    else if (a < -19'sd32768)
      reduce = 16'h8000;
    else
      reduce = a[15:0];
`else
    reduce = a[15:0];
`endif
  endfunction

  always_ff @(posedge bit_clock_in or posedge rst_active_high) begin
    if (rst_active_high) begin
      state          <= IDLE;
      frame_count    <= '0;
      idx            <= '0;
      tcnt           <= '0;
      mute_q         <= '0;
      acc_l          <= '0;
      acc_r          <= '0;
      any_ack        <= 1'b0;
      voice_req      <= '0;
      voice_sel      <= '0;
      pcm_data_left  <= '0;
      pcm_data_right <= '0;
      pcm_data_valid <= 1'b0;
      frame_strobe   <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      frame_count  <= (frame_count == LAST) ? '0 : frame_count + CW'(1);
      frame_strobe <= (frame_count == LAST);
      if (overrun_clr)
        overrun <= 1'b0;
      // Commit beats the poller; an unfinished poll is cut short here.
      if (frame_count == COMMIT) begin
        pcm_data_left  <= reduce(acc_l);
        pcm_data_right <= reduce(acc_r);
        pcm_data_valid <= any_ack;
        if (state == SELECT || state == WAIT)
          overrun <= 1'b1;
        state     <= IDLE;
        voice_req <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (frame_count == '0) begin
              acc_l   <= '0;
              acc_r   <= '0;
              any_ack <= 1'b0;
              mute_q  <= voice_mute;
              idx     <= '0;
              if (mix_enable)
                state <= SELECT;
            end
          end
          SELECT: begin
            if (idx == IDX_END) begin
              state <= DONE;
            end else if (|(mute_q & sel_onehot)) begin
              idx <= idx + 4'd1;
            end else begin
              voice_req <= sel_onehot;
              voice_sel <= idx[2:0];
              tcnt      <= '0;
              state     <= WAIT;
            end
          end
          WAIT: begin
            if (voice_ack) begin
              acc_l     <= acc_l + {{3{voice_left[15]}}, voice_left};
              acc_r     <= acc_r + {{3{voice_right[15]}}, voice_right};
              any_ack   <= 1'b1;
              voice_req <= '0;
              idx       <= idx + 4'd1;
              state     <= SELECT;
            end else if (tcnt == TO_LAST) begin
              voice_req <= '0;
              idx       <= idx + 4'd1;
              state     <= SELECT;
            end else begin
              tcnt <= tcnt + 3'd1;
            end
          end
          DONE: state <= DONE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pcm_voice_mix_scheduler.sv
// Scoreboard bench for pcm_voice_mix_scheduler: per-frame expectations
// are queued by the stimulus and checked by a monitor at each frame strobe.
module tb_pcm_voice_mix_scheduler;

  localparam int NV = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mix_enable = 1'b0;
  logic [NV-1:0] voice_mute = '0;
  logic [NV-1:0] voice_req;
  logic [2:0]    voice_sel;
  logic          voice_ack = 1'b0;
  logic [15:0]   voice_left = '0;
  logic [15:0]   voice_right = '0;
  logic [15:0]   pcm_l, pcm_r;
  logic          pcm_v, strobe, ovr;
  logic          clr = 1'b0;

  logic [7:0]    req2;
  logic [2:0]    sel2;
  logic [15:0]   l2, r2;
  logic          v2, strobe2, ovr2;
  logic          clr2 = 1'b0;

  always #5 clk = ~clk;

  pcm_voice_mix_scheduler #(.NUM_VOICES(4), .ACK_TIMEOUT(4), .FRAME_BITS(32)) dut (
    .bit_clock_in(clk), .rst_active_high(rst), .mix_enable(mix_enable),
    .voice_mute(voice_mute), .voice_req(voice_req), .voice_sel(voice_sel),
    .voice_ack(voice_ack), .voice_left(voice_left), .voice_right(voice_right),
    .pcm_data_left(pcm_l), .pcm_data_right(pcm_r), .pcm_data_valid(pcm_v),
    .frame_strobe(strobe), .overrun(ovr), .overrun_clr(clr)
  );

  pcm_voice_mix_scheduler #(.NUM_VOICES(8), .ACK_TIMEOUT(7), .FRAME_BITS(32)) dut_ov (
    .bit_clock_in(clk), .rst_active_high(rst), .mix_enable(1'b1),
    .voice_mute(8'h00), .voice_req(req2), .voice_sel(sel2),
    .voice_ack(1'b0), .voice_left(16'h0000), .voice_right(16'h0000),
    .pcm_data_left(l2), .pcm_data_right(r2), .pcm_data_valid(v2),
    .frame_strobe(strobe2), .overrun(ovr2), .overrun_clr(clr2)
  );

  typedef struct packed {
    logic [15:0]         l;
    logic [15:0]         r;
    logic                v;
    logic [NV-1:0][7:0]  rc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  int lat[NV];
  logic [15:0] vl[NV];
  logic [15:0] vr[NV];
  int ser_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] l, input logic [15:0] r,
                              input logic v, input logic [31:0] rc);
    exp_t e;
    e.l = l;
    e.r = r;
    e.v = v;
    e.rc = rc;
    return e;
  endfunction

  // serializer's bit counter, reset with the same line
  always @(posedge clk or posedge rst)
    if (rst) ser_cnt <= 0;
    else ser_cnt <= (ser_cnt + 1) % 32;

  // voice model: ack after lat[v] cycles of request, lat 0 = never
  int wcnt = 0;
  always @(negedge clk) begin
    if (voice_req != '0) begin
      wcnt = wcnt + 1;
      if (lat[voice_sel] != 0 && wcnt >= lat[voice_sel]) begin
        voice_ack   = 1'b1;
        voice_left  = vl[voice_sel];
        voice_right = vr[voice_sel];
      end else begin
        voice_ack = 1'b0;
      end
    end else begin
      wcnt = 0;
      voice_ack = 1'b0;
    end
  end

  // monitor
  int rcnt[NV];
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      for (int v = 0; v < NV; v++) rcnt[v] = 0;
    end else begin
      if (!$onehot0(voice_req))
        chk("req_onehot", 32'(voice_req), 32'h0);
      if (strobe) begin
        if (q.size() == 0) begin
          chk("sb_underflow", 32'h1, 32'h0);
        end else begin
          e = q.pop_front();
          chk("left", 32'(pcm_l), 32'(e.l));
          chk("right", 32'(pcm_r), 32'(e.r));
          chk("valid", 32'(pcm_v), 32'(e.v));
          chk("overrun", 32'(ovr), 32'h0);
          for (int v = 0; v < NV; v++)
            chk($sformatf("req%0d_cycles", v), 32'(rcnt[v]), 32'(e.rc[v]));
        end
        for (int v = 0; v < NV; v++) rcnt[v] = 0;
      end
      for (int v = 0; v < NV; v++)
        if (voice_req[v]) rcnt[v]++;
    end
  end

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!strobe && n < 40);
    if (!strobe) chk("frame_timeout", 32'(n), 32'd32);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] sat_l, sat_r;
    int n;
`ifdef PCM_MIX_SATURATE_EN
    sat_l = 16'h7fff;
    sat_r = 16'h8000;
`else
    sat_l = 16'hc000;
    sat_r = 16'h4000;
`endif
    // F0 basic mix
    mix_enable = 1'b1;
    lat = '{1, 1, 1, 1};
    vl = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    vr = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
    q.push_back(mk(16'h0a00, 16'h0a00, 1'b1, {8'd1, 8'd1, 8'd1, 8'd1}));
    #12;
    chk("rst_pcm_l", 32'(pcm_l), 32'h0);
    chk("rst_req", 32'(voice_req), 32'h0);
    @(negedge clk) rst = 1'b0;
    wait_frame();
    chk("ov_set", 32'(ovr2), 32'h1);
    chk("ov_valid", 32'(v2), 32'h0);
    chk("ov_req", 32'(req2), 32'h0);
    chk("ov_left", 32'(l2), 32'h0);

    // F1 mute voice 1, voice 2 times out
    voice_mute = 4'b0010;
    lat = '{1, 1, 0, 1};
    vl = '{16'h1000, 16'h5555, 16'h7777, 16'h1000};
    vr = '{16'h0010, 16'h5555, 16'h7777, 16'h0010};
    q.push_back(mk(16'h2000, 16'h0020, 1'b1, {8'd1, 8'd4, 8'd0, 8'd1}));
    clr2 = 1'b1;
    @(negedge clk) clr2 = 1'b0;
    chk("ov_clr", 32'(ovr2), 32'h0);
    wait_frame();

    // F2 overflow of the mix
    voice_mute = '0;
    lat = '{2, 2, 2, 2};
    vl = '{16'h7000, 16'h7000, 16'h7000, 16'h7000};
    vr = '{16'h9000, 16'h9000, 16'h9000, 16'h9000};
    q.push_back(mk(sat_l, sat_r, 1'b1, {8'd2, 8'd2, 8'd2, 8'd2}));
    clr2 = 1'b1;
    @(negedge clk) clr2 = 1'b0;
    chk("ov_clr2", 32'(ovr2), 32'h0);
    n = 0;
    while (ser_cnt != 30 && n < 40) begin
      @(negedge clk);
      n++;
    end
    clr2 = 1'b1;
    @(negedge clk) clr2 = 1'b0;
    chk("ov_set_wins", 32'(ovr2), 32'h1);
    chk("ov_req_commit", 32'(req2), 32'h0);
    wait_frame();

    // F3 mixing disabled
    mix_enable = 1'b0;
    lat = '{1, 1, 1, 1};
    q.push_back(mk(16'h0, 16'h0, 1'b0, 32'h0));
    wait_frame();

    // F4 every voice times out
    mix_enable = 1'b1;
    lat = '{0, 0, 0, 0};
    q.push_back(mk(16'h0, 16'h0, 1'b0, {8'd4, 8'd4, 8'd4, 8'd4}));
    wait_frame();

    // F5 enable drops mid-sequence, frame still completes
    lat = '{3, 3, 3, 3};
    vl = '{16'h0001, 16'h0001, 16'h0001, 16'h0001};
    vr = '{16'hffff, 16'hffff, 16'hffff, 16'hffff};
    q.push_back(mk(16'h0004, 16'hfffc, 1'b1, {8'd3, 8'd3, 8'd3, 8'd3}));
    repeat (5) @(negedge clk);
    mix_enable = 1'b0;
    wait_frame();

    // reset while a voice is waited on
    mix_enable = 1'b1;
    lat = '{0, 0, 0, 0};
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_rst_req", 32'(voice_req), 32'h1);
    rst = 1'b1;
    #1;
    chk("arst_req", 32'(voice_req), 32'h0);
    chk("arst_sel", 32'(voice_sel), 32'h0);
    chk("arst_left", 32'(pcm_l), 32'h0);
    chk("arst_right", 32'(pcm_r), 32'h0);
    chk("arst_valid", 32'(pcm_v), 32'h0);
    chk("arst_strobe", 32'(strobe), 32'h0);
    chk("arst_ov2", 32'(ovr2), 32'h0);
    q.delete();
    repeat (3) @(negedge clk);
    mix_enable = 1'b0;
    q.push_back(mk(16'h0, 16'h0, 1'b0, 32'h0));
    rst = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!strobe && n < 40);
    chk("strobe_latency", 32'(n), 32'd32);
    chk("strobe_ser_cnt", 32'(ser_cnt), 32'h0);
    @(negedge clk);
    chk("sb_drained", 32'(q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
